mac_column_compensator: RTL and testbench
=========================================

Name: mac_column_compensator

Overview:
- Downstream consumer of the grouped 8-input MAC at the bottom of each systolic column.
- Takes, per beat, the MAC group's 24-bit partial sum, its 16-bit deferred error product and its error flag.
- Adds back the error product wherever the flag is set, accumulates TILES beats into one column result, and presents that result through a one-deep valid/ready output register.
- Also counts compensated errors and flags saturation.

Parameters:
PSUM_W, 24, partial-sum input width
EPROD_W, 16, error-product input width
ACC_W, 32, accumulator/result width; must be >= PSUM_W+1
TILES, 4, beats per output result; must be >= 1
CNT_W, 8, error-counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of the in-progress group
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
psum_in  in  PSUM_W  partial sum from MAC group (unsigned)
eprod_in  in  EPROD_W  deferred error product (unsigned)
err_in  in  1  eprod_in is valid and must be compensated
out_valid  out  1  result register holds a result
out_ready  in  1  downstream accepts result
acc_out  out  ACC_W  compensated column result
err_count_out  out  CNT_W  number of beats in the group with err_in=1
sat_out  out  1  group saturated

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, tile_cnt=0, err_cnt=0, sat=0, FSM=IDLE, out_valid=0, acc_out=0, err_count_out=0, sat_out=0. Reset mid-group discards everything, including a pending output.
- Accept: accept = in_valid & in_ready.
- Term: term = zero_ext(psum_in) + (err_in ? zero_ext(eprod_in) : 0). eprod_in is ignored when err_in=0.
- Sum: sum = acc + term, computed ACC_W+1 wide. If the carry is set, the result clamps to 2^ACC_W-1 and sat is set (sticky within the group).
- err_cnt: increments on an accepted beat with err_in=1; saturates at 2^CNT_W-1.
- FSM IDLE: acc=0, tile_cnt=0. An accepted beat moves to ACCUM. With TILES=1, an accepted beat completes immediately and the FSM stays in IDLE.
- FSM ACCUM: each accepted beat updates acc and tile_cnt++.
- Final beat (tile_cnt==TILES-1) on accept:
  - acc_out <= sum (clamped); err_count_out and sat_out <= their updated values; out_valid <= 1.
  - acc, tile_cnt, err_cnt and sat clear to 0; FSM goes to IDLE.
  - Latency: result visible on the cycle after the last beat is accepted.
- in_ready = !(tile_cnt==TILES-1 && out_valid && !out_ready). Stalling happens only at the last beat while an undrained result is pending. A simultaneous drain and load in the same cycle is allowed: the old result leaves and the new one loads, with out_valid staying 1.
- Output handshake: out_valid falls when out_ready=1 and no new result loads that cycle. acc_out, err_count_out and sat_out hold stable while out_valid=1 and out_ready=0.
- clear (sync, priority over accept): acc, tile_cnt, err_cnt and sat go to 0, FSM to IDLE; a beat presented in the same cycle is dropped. The output register and out_valid are untouched, so a pending result survives clear.
- in_ready is combinational from registered state and out_ready. There is no combinational path from in_valid to out_valid.

Test Plan:
- TILES=4, err_in=0: four beats of psum_in=0x0082E8 -> one cycle after the 4th accept, out_valid=1, acc_out=0x00020BA0, err_count_out=0, sat_out=0.
- TILES=4: beats 0x0082E8 with err_in=1/eprod_in=0x0012 on beats 2 and 4, and err_in=0/eprod_in=0xFFFF on beats 1 and 3 -> acc_out=0x00020BC4, err_count_out=2.
- Backpressure: out_ready=0 with a result pending, feed the next group -> in_ready=0 only at the 4th beat and the first result holds. Then raise out_ready -> the same cycle accepts the 4th beat, the next cycle shows acc_out=new result with out_valid=1 continuous.
- ACC_W=25, TILES=4: four beats of 0xFFFFFF -> acc_out=0x1FFFFFF, sat_out=1. The next group of 4x0x000001 gives acc_out=0x4, sat_out=0.
- clear after 2 beats of 0x0082E8, then 4 beats of 0x000010 -> acc_out=0x40. A pending prior result asserted across the clear remains valid and unchanged.
- Assert rst_n=0 asynchronously mid-group with out_valid=1 -> all outputs 0 immediately. After release, a fresh 4-beat group of 0x0082E8 gives 0x20BA0.

Source files
------------

// File: rtl/mac_column_compensator.sv
// Column-bottom compensator: adds deferred error products back into MAC partial sums,
// accumulates TILES beats per result and hands the result out through a one-deep register.
module mac_column_compensator #(
    parameter int PSUM_W  = 24,
    parameter int EPROD_W = 16,
    parameter int ACC_W   = 32,
    parameter int TILES   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PSUM_W-1:0]  psum_in,
    input  logic [EPROD_W-1:0] eprod_in,
    input  logic               err_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]   err_count_out,
    output logic               sat_out
);
    localparam int TC_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam logic [TC_W-1:0] LAST_TILE = TC_W'(TILES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready depends only on registered state and out_ready, never on in_valid.
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [TC_W-1:0]   tile_cnt, tile_cnt_nxt;
    logic [CNT_W-1:0]  err_cnt, err_cnt_nxt;
    logic              sat, sat_nxt;

    logic              last_tile;
    logic              accept;
    logic              load_out;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    term;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  sum_clamped;
    logic [CNT_W-1:0]  err_upd;
    logic              sat_upd;

    assign last_tile = (tile_cnt == LAST_TILE);
    assign in_ready  = !(last_tile && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign load_out  = accept && last_tile && !clear;

    // A fresh group always starts from zero, whatever acc last held.
    assign acc_base    = (state == ACCUM) ? acc : '0;
    assign term        = (ACC_W + 1)'(psum_in) + (err_in ? (ACC_W + 1)'(eprod_in) : '0);
    assign sum         = {1'b0, acc_base} + term;
    assign sum_clamped = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    assign sat_upd     = sat | sum[ACC_W];
    assign err_upd     = (err_in && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            tile_cnt <= '0;
            err_cnt  <= '0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            tile_cnt <= tile_cnt_nxt;
            err_cnt  <= err_cnt_nxt;
            sat      <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        tile_cnt_nxt = tile_cnt;
        err_cnt_nxt  = err_cnt;
        sat_nxt      = sat;
        if (clear || (accept && last_tile)) begin
            state_nxt    = IDLE;
            acc_nxt      = '0;
            tile_cnt_nxt = '0;
            err_cnt_nxt  = '0;
            sat_nxt      = 1'b0;
        end else if (accept) begin
            state_nxt    = ACCUM;
            acc_nxt      = sum_clamped;
            tile_cnt_nxt = tile_cnt + TC_W'(1);
            err_cnt_nxt  = err_upd;
            sat_nxt      = sat_upd;
        end
    end

    // Output register survives clear; a drain and a load in the same cycle keep out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            acc_out       <= '0;
            err_count_out <= '0;
            sat_out       <= 1'b0;
        end else if (load_out) begin
            out_valid     <= 1'b1;
            acc_out       <= sum_clamped;
            err_count_out <= err_upd;
            sat_out       <= sat_upd;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mac_column_compensator.sv
// Bench for mac_column_compensator: directed scenarios plus random traffic, checked by a
// queue scoreboard fed from a group-level arithmetic model.
module tb_mac_column_compensator;
    localparam int PSUM_W  = 24;
    localparam int EPROD_W = 16;
    localparam int ACC_W   = 25;
    localparam int TILES   = 4;
    localparam int CNT_W   = 8;
    localparam int EXP_W   = ACC_W + CNT_W + 1;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PSUM_W-1:0]  psum_in = '0;
    logic [EPROD_W-1:0] eprod_in = '0;
    logic               err_in = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [ACC_W-1:0]   acc_out;
    logic [CNT_W-1:0]   err_count_out;
    logic               sat_out;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    logic [EXP_W-1:0] exp_q[$];
    longint unsigned  grp_sum = 0;
    int               grp_n = 0;
    int               grp_err = 0;

    mac_column_compensator #(
        .PSUM_W(PSUM_W), .EPROD_W(EPROD_W), .ACC_W(ACC_W), .TILES(TILES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .psum_in(psum_in), .eprod_in(eprod_in), .err_in(err_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .err_count_out(err_count_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a group result is the plain sum of its terms, clamped once at the end.
    task automatic model_beat(input logic [PSUM_W-1:0] p, input logic [EPROD_W-1:0] e,
                              input logic er);
        logic [ACC_W-1:0] a;
        logic [CNT_W-1:0] c;
        logic             s;
        grp_sum += longint'(p) + (er ? longint'(e) : 0);
        if (er) grp_err++;
        grp_n++;
        if (grp_n == TILES) begin
            s = (grp_sum > ACC_MAX);
            a = s ? ACC_MAX[ACC_W-1:0] : grp_sum[ACC_W-1:0];
            c = (grp_err > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(grp_err);
            exp_q.push_back({s, c, a});
            model_reset();
        end
    endtask

    task automatic model_reset();
        grp_sum = 0;
        grp_n   = 0;
        grp_err = 0;
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", acc_out, $time);
            end else begin
                check("result", 64'({sat_out, err_count_out, acc_out}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [PSUM_W-1:0] p, input logic [EPROD_W-1:0] e,
                             input logic er);
        int waited = 0;
        in_valid = 1'b1;
        psum_in  = p;
        eprod_in = e;
        err_in   = er;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model_beat(p, e, er);
        end
    endtask

    task automatic do_clear(input logic with_beat);
        logic [31:0] r;
        r        = $urandom;
        clear    = 1'b1;
        in_valid = with_beat;
        psum_in  = r[PSUM_W-1:0];
        eprod_in = r[EPROD_W-1:0];
        err_in   = r[31];
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_reset();
    endtask

    task automatic wait_drain();
        int n = 0;
        ready_mode = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [PSUM_W-1:0] p);
        for (int i = 0; i < TILES; i++) send_beat(p, 16'h0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc_out", 64'(acc_out), 64'd0);
        check("rst_err_count", 64'(err_count_out), 64'd0);
        check("rst_sat_out", 64'(sat_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Plain group, then one with compensation on beats 2 and 4.
        send_group(24'h0082E8);
        check("latency_valid", 64'(out_valid), 64'd1);
        send_beat(24'h0082E8, 16'hFFFF, 1'b0);
        send_beat(24'h0082E8, 16'h0012, 1'b1);
        send_beat(24'h0082E8, 16'hFFFF, 1'b0);
        send_beat(24'h0082E8, 16'h0012, 1'b1);
        wait_drain();

        // Backpressure: stall only at the last beat, then drain and load together.
        ready_mode = 2;
        send_group(24'h0082E8);
        for (int i = 1; i < TILES; i++) begin
            in_valid = 1'b1;
            psum_in  = PSUM_W'(i * 256);
            err_in   = 1'b0;
            @(negedge clk);
            check("bp_ready_early", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model_beat(PSUM_W'(i * 256), 16'h0, 1'b0);
        end
        in_valid = 1'b1;
        psum_in  = 24'h000400;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_stall", 64'(in_ready), 64'd0);
        end
        ready_mode = 0;
        @(negedge clk);
        check("bp_ready_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_beat(24'h000400, 16'h0, 1'b0);
        @(negedge clk);
        check("bp_valid_continuous", 64'(out_valid), 64'd1);
        wait_drain();

        // Saturation, then a clean group afterwards.
        send_group(24'hFFFFFF);
        send_group(24'h000001);
        wait_drain();

        // clear mid-group with an older result still pending.
        ready_mode = 2;
        send_group(24'h000055);
        send_beat(24'h0082E8, 16'h0, 1'b0);
        send_beat(24'h0082E8, 16'h0, 1'b0);
        do_clear(1'b1);
        repeat (2) @(posedge clk);
        #1;
        wait_drain();
        send_group(24'h000010);
        wait_drain();

        // Asynchronous reset mid-group with a pending result.
        ready_mode = 2;
        send_group(24'h001234);
        send_beat(24'h0082E8, 16'h0, 1'b0);
        send_beat(24'h0082E8, 16'h0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_acc", 64'(acc_out), 64'd0);
        check("async_rst_err", 64'(err_count_out), 64'd0);
        check("async_rst_sat", 64'(sat_out), 64'd0);
        exp_q.delete();
        model_reset();
        ready_mode = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_group(24'h0082E8);
        wait_drain();

        // Random traffic with random backpressure and occasional clears.
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                do_clear(1'($urandom_range(0, 1)));
            end else if (sel < 4) begin
                @(posedge clk);
                #1;
            end else begin
                r = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 32'h000FFFFF);
                send_beat(r[PSUM_W-1:0], 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
